// File: rtl/regfile_initiator_if.sv
// Command/response handshake bundle for regfile_initiator.
//   master : command source side (sequencer, UART bridge, CPU stub)
//   slave  : regfile_initiator side
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr/cmd_wdata   target address and write data
//   rsp_valid/rsp_ready  read response handshake
//   rsp_rdata/rsp_err    read data and out-of-range flag
interface regfile_initiator_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [WIDTH-1:0]  cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_rdata;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/regfile_initiator.sv
// Host-side bus initiator for the DEPTH x WIDTH register file. Turns each
// accepted command into one single-cycle register-file access, returns read
// data over a held response handshake, and optionally clears every location
// after reset before accepting commands.
// Ports:
//   CLK, RST   clock and synchronous active-high reset
//   bus        command/response handshake (slave modport)
//   init_done  sticky, high once the init sweep has finished
//   WrEn/RdEn  register file enables (never high together)
//   Address    register file address
//   WrData     register file write data
//   RdData     register file read data (registered inside the register file)
//
// state | meaning
// INIT  | sweeping INIT_VALUE into every location
// IDLE  | cmd_ready high, waiting for a command
// WRITE | WrEn pulse cycle (suppressed for out-of-range address)
// READ  | RdEn pulse cycle
// WAIT  | RD_LAT cycles until RdData is valid
// RESP  | response held until rsp_ready
module regfile_initiator #(
   parameter int              WIDTH      = 16,
   parameter int              DEPTH      = 8,
   parameter int              ADDR_W     = 3,
   parameter int              RD_LAT     = 1,
   parameter int              INIT_EN    = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic               CLK,
   input  logic               RST,
   regfile_initiator_if.slave bus,
   output logic               init_done,
   output logic               WrEn,
   output logic               RdEn,
   output logic [ADDR_W-1:0]  Address,
   output logic [WIDTH-1:0]   WrData,
   input  logic [WIDTH-1:0]   RdData
);

   typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, WAIT, RESP} state_t;

   localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W+1)'(DEPTH);
   localparam logic [2:0]      WAIT_LOAD = 3'(RD_LAT-1);

   state_t            state, nextState;
   logic [ADDR_W:0]   initCnt, initCntNxt;
   logic [2:0]        waitCnt, waitCntNxt;
   logic              wrEnNxt, rdEnNxt, initDoneNxt;
   logic [ADDR_W-1:0] addrNxt;
   logic [WIDTH-1:0]  wrDataNxt;
   logic              rspValidNxt, rspErrNxt;
   logic [WIDTH-1:0]  rspRdataNxt;
   logic              cmdInRange;

   assign cmdInRange    = ({1'b0, bus.cmd_addr} < DEPTH_V);
   assign bus.cmd_ready = (state == IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= (INIT_EN != 0) ? INIT : IDLE;
         initCnt       <= '0;
         waitCnt       <= '0;
         WrEn          <= 1'b0;
         RdEn          <= 1'b0;
         Address       <= '0;
         WrData        <= '0;
         init_done     <= (INIT_EN == 0);
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         state         <= nextState;
         initCnt       <= initCntNxt;
         waitCnt       <= waitCntNxt;
         WrEn          <= wrEnNxt;
         RdEn          <= rdEnNxt;
         Address       <= addrNxt;
         WrData        <= wrDataNxt;
         init_done     <= initDoneNxt;
         bus.rsp_valid <= rspValidNxt;
         bus.rsp_rdata <= rspRdataNxt;
         bus.rsp_err   <= rspErrNxt;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         INIT:    if (initCnt == DEPTH_V) nextState = IDLE;
         IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_write)   nextState = WRITE;
               else if (cmdInRange) nextState = READ;
               else                 nextState = RESP;
            end
         end
         WRITE:   nextState = IDLE;
         READ:    nextState = WAIT;
         WAIT:    if (waitCnt == '0) nextState = RESP;
         RESP:    if (bus.rsp_ready) nextState = IDLE;
         default: nextState = INIT;
      endcase
   end

   // Enables default low so every access is a single-cycle pulse; address,
   // data and response registers hold unless explicitly updated.
   always_comb begin
      initCntNxt  = initCnt;
      waitCntNxt  = waitCnt;
      wrEnNxt     = 1'b0;
      rdEnNxt     = 1'b0;
      addrNxt     = Address;
      wrDataNxt   = WrData;
      initDoneNxt = init_done;
      rspValidNxt = bus.rsp_valid;
      rspRdataNxt = bus.rsp_rdata;
      rspErrNxt   = bus.rsp_err;
      case (state)
         INIT: begin
            if (initCnt == DEPTH_V) begin
               initDoneNxt = 1'b1;
            end else begin
               wrEnNxt    = 1'b1;
               addrNxt    = initCnt[ADDR_W-1:0];
               wrDataNxt  = INIT_VALUE;
               initCntNxt = initCnt + 1'b1;
            end
         end
         IDLE: begin
            if (bus.cmd_valid) begin
               addrNxt = bus.cmd_addr;
               if (bus.cmd_write) begin
                  wrDataNxt = bus.cmd_wdata;
                  wrEnNxt   = cmdInRange;
               end else if (cmdInRange) begin
                  rdEnNxt = 1'b1;
               end else begin
                  rspValidNxt = 1'b1;
                  rspRdataNxt = '0;
                  rspErrNxt   = 1'b1;
               end
            end
         end
         READ:    waitCntNxt = WAIT_LOAD;
         WAIT: begin
            if (waitCnt == '0) begin
               rspValidNxt = 1'b1;
               rspRdataNxt = RdData;
               rspErrNxt   = 1'b0;
            end else begin
               waitCntNxt = waitCnt - 1'b1;
            end
         end
         RESP:    if (bus.rsp_ready) rspValidNxt = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regfile_initiator.sv
module tb_regfile_initiator;
   localparam int W  = 16;
   localparam int AW = 3;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic rstA, rstB;
   regfile_initiator_if #(.WIDTH(W), .ADDR_W(AW)) ifA ();
   regfile_initiator_if #(.WIDTH(W), .ADDR_W(AW)) ifB ();

   logic          initDoneA, WrEnA, RdEnA, initDoneB, WrEnB, RdEnB;
   logic [AW-1:0] AddressA, AddressB;
   logic [W-1:0]  WrDataA, RdDataA, WrDataB, RdDataB;

   regfile_initiator #(.WIDTH(W), .DEPTH(8), .ADDR_W(AW), .RD_LAT(1)) dutA (
      .CLK(CLK), .RST(rstA), .bus(ifA), .init_done(initDoneA), .WrEn(WrEnA),
      .RdEn(RdEnA), .Address(AddressA), .WrData(WrDataA), .RdData(RdDataA));

   regfile_initiator #(.WIDTH(W), .DEPTH(6), .ADDR_W(AW), .RD_LAT(1)) dutB (
      .CLK(CLK), .RST(rstB), .bus(ifB), .init_done(initDoneB), .WrEn(WrEnB),
      .RdEn(RdEnB), .Address(AddressB), .WrData(WrDataB), .RdData(RdDataB));

   // Register file models with registered read data
   logic [W-1:0] memA [8];
   logic [W-1:0] memB [8];
   always @(posedge CLK) begin
      if (WrEnA) memA[AddressA] <= WrDataA;
      if (RdEnA) RdDataA <= memA[AddressA];
      if (WrEnB) memB[AddressB] <= WrDataB;
      if (RdEnB) RdDataB <= memB[AddressB];
   end

   int wrCntA = 0, rdCntA = 0, wrCntB = 0, rdCntB = 0;
   always @(posedge CLK) begin
      if (WrEnA === 1'b1) wrCntA <= wrCntA + 1;
      if (RdEnA === 1'b1) rdCntA <= rdCntA + 1;
      if (WrEnB === 1'b1) wrCntB <= wrCntB + 1;
      if (RdEnB === 1'b1) rdCntB <= rdCntB + 1;
   end

   int passCnt = 0, totalCnt = 0;

   // Presents a command on A at a negedge and returns at the negedge after
   // the accepting edge.
   task automatic sendA(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                        output bit acc);
      acc = 1'b0;
      ifA.cmd_valid = 1'b1; ifA.cmd_write = wr; ifA.cmd_addr = a; ifA.cmd_wdata = d;
      for (int i = 0; i < 20; i++) begin
         if (ifA.cmd_ready === 1'b1) begin acc = 1'b1; break; end
         @(negedge CLK);
      end
      @(negedge CLK);
      ifA.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      totalCnt++;
      if ({WrEnA, RdEnA, AddressA, WrDataA, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err,
           initDoneA, ifA.cmd_ready} !== '0)
         $display("FAIL reset_values: got we=%b re=%b a=%0d wd=%0h rv=%b rd=%0h err=%b done=%b rdy=%b expected all 0",
                  WrEnA, RdEnA, AddressA, WrDataA, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err,
                  initDoneA, ifA.cmd_ready);
      else passCnt++;
      rstA = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         totalCnt++;
         if (WrEnA !== 1'b1 || AddressA !== AW'(i) || WrDataA !== 16'h0 || ifA.cmd_ready !== 1'b0)
            $display("FAIL init_sweep[%0d]: got we=%b a=%0d wd=%0h rdy=%b expected we=1 a=%0d wd=0 rdy=0",
                     i, WrEnA, AddressA, WrDataA, ifA.cmd_ready, i);
         else passCnt++;
      end
      @(negedge CLK);
      totalCnt++;
      if (WrEnA !== 1'b0 || initDoneA !== 1'b1 || ifA.cmd_ready !== 1'b1)
         $display("FAIL init_end: got we=%b done=%b rdy=%b expected we=0 done=1 rdy=1",
                  WrEnA, initDoneA, ifA.cmd_ready);
      else passCnt++;
   endtask

   task automatic test_write_read();
      int w0, r0;
      bit acc;
      w0 = wrCntA; r0 = rdCntA;
      ifA.rsp_ready = 1'b1;
      sendA(1'b1, 3'd2, 16'd14, acc);
      totalCnt++;
      if (!acc || WrEnA !== 1'b1 || AddressA !== 3'd2 || WrDataA !== 16'd14 || RdEnA !== 1'b0)
         $display("FAIL wr_pulse: got acc=%b we=%b re=%b a=%0d wd=%0d expected acc=1 we=1 re=0 a=2 wd=14",
                  acc, WrEnA, RdEnA, AddressA, WrDataA);
      else passCnt++;
      @(negedge CLK);
      totalCnt++;
      if (WrEnA !== 1'b0 || ifA.cmd_ready !== 1'b1)
         $display("FAIL wr_done: got we=%b rdy=%b expected we=0 rdy=1", WrEnA, ifA.cmd_ready);
      else passCnt++;
      sendA(1'b0, 3'd2, 16'h0, acc);
      totalCnt++;
      if (!acc || RdEnA !== 1'b1 || WrEnA !== 1'b0 || AddressA !== 3'd2)
         $display("FAIL rd_pulse: got acc=%b re=%b we=%b a=%0d expected acc=1 re=1 we=0 a=2",
                  acc, RdEnA, WrEnA, AddressA);
      else passCnt++;
      @(negedge CLK);
      totalCnt++;
      if (ifA.rsp_valid !== 1'b0 || RdEnA !== 1'b0)
         $display("FAIL rd_early: got rv=%b re=%b expected rv=0 re=0", ifA.rsp_valid, RdEnA);
      else passCnt++;
      @(negedge CLK);
      totalCnt++;
      if (ifA.rsp_valid !== 1'b1 || ifA.rsp_rdata !== 16'd14 || ifA.rsp_err !== 1'b0)
         $display("FAIL rd_resp: got rv=%b rd=%0d err=%b expected rv=1 rd=14 err=0",
                  ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err);
      else passCnt++;
      @(negedge CLK);
      totalCnt++;
      if (ifA.rsp_valid !== 1'b0 || ifA.cmd_ready !== 1'b1)
         $display("FAIL rd_handshake: got rv=%b rdy=%b expected rv=0 rdy=1", ifA.rsp_valid, ifA.cmd_ready);
      else passCnt++;
      totalCnt++;
      if (wrCntA - w0 != 1 || rdCntA - r0 != 1)
         $display("FAIL pulse_counts: got wr=%0d rd=%0d expected wr=1 rd=1", wrCntA - w0, rdCntA - r0);
      else passCnt++;
   endtask

   task automatic test_resp_hold();
      bit acc;
      ifA.rsp_ready = 1'b0;
      sendA(1'b1, 3'd3, 16'd6, acc);
      @(negedge CLK);
      sendA(1'b0, 3'd3, 16'h0, acc);
      @(negedge CLK);
      @(negedge CLK);
      for (int i = 0; i < 5; i++) begin
         totalCnt++;
         if (ifA.rsp_valid !== 1'b1 || ifA.rsp_rdata !== 16'd6 || ifA.rsp_err !== 1'b0 ||
             ifA.cmd_ready !== 1'b0)
            $display("FAIL resp_hold[%0d]: got rv=%b rd=%0d err=%b rdy=%b expected rv=1 rd=6 err=0 rdy=0",
                     i, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err, ifA.cmd_ready);
         else passCnt++;
         @(negedge CLK);
      end
      ifA.rsp_ready = 1'b1;
      @(negedge CLK);
      totalCnt++;
      if (ifA.rsp_valid !== 1'b0 || ifA.cmd_ready !== 1'b1)
         $display("FAIL resp_release: got rv=%b rdy=%b expected rv=0 rdy=1", ifA.rsp_valid, ifA.cmd_ready);
      else passCnt++;
   endtask

   task automatic test_back_to_back();
      ifA.rsp_ready = 1'b1;
      ifA.cmd_valid = 1'b1; ifA.cmd_write = 1'b1; ifA.cmd_addr = 3'd1; ifA.cmd_wdata = 16'd5;
      @(negedge CLK);
      totalCnt++;
      if (ifA.cmd_ready !== 1'b0 || WrEnA !== 1'b1 || AddressA !== 3'd1 || WrDataA !== 16'd5)
         $display("FAIL b2b_write: got rdy=%b we=%b a=%0d wd=%0d expected rdy=0 we=1 a=1 wd=5",
                  ifA.cmd_ready, WrEnA, AddressA, WrDataA);
      else passCnt++;
      ifA.cmd_write = 1'b0; ifA.cmd_wdata = 16'h0;
      @(negedge CLK);
      totalCnt++;
      if (ifA.cmd_ready !== 1'b1 || RdEnA !== 1'b0 || WrEnA !== 1'b0)
         $display("FAIL b2b_gap: got rdy=%b re=%b we=%b expected rdy=1 re=0 we=0",
                  ifA.cmd_ready, RdEnA, WrEnA);
      else passCnt++;
      @(negedge CLK);
      ifA.cmd_valid = 1'b0;
      totalCnt++;
      if (RdEnA !== 1'b1 || ifA.cmd_ready !== 1'b0 || AddressA !== 3'd1)
         $display("FAIL b2b_read: got re=%b rdy=%b a=%0d expected re=1 rdy=0 a=1",
                  RdEnA, ifA.cmd_ready, AddressA);
      else passCnt++;
      @(negedge CLK);
      @(negedge CLK);
      totalCnt++;
      if (ifA.rsp_valid !== 1'b1 || ifA.rsp_rdata !== 16'd5 || ifA.rsp_err !== 1'b0)
         $display("FAIL b2b_resp: got rv=%b rd=%0d err=%b expected rv=1 rd=5 err=0",
                  ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err);
      else passCnt++;
      @(negedge CLK);
      totalCnt++;
      if (ifA.rsp_valid !== 1'b0 || ifA.cmd_ready !== 1'b1)
         $display("FAIL b2b_end: got rv=%b rdy=%b expected rv=0 rdy=1", ifA.rsp_valid, ifA.cmd_ready);
      else passCnt++;
   endtask

   task automatic test_out_of_range();
      int w0, r0, n;
      rstB = 1'b0;
      n = 0;
      while (initDoneB !== 1'b1 && n < 30) begin @(negedge CLK); n++; end
      totalCnt++;
      if (initDoneB !== 1'b1 || wrCntB != 6 || AddressB !== 3'd5)
         $display("FAIL oor_init: got done=%b writes=%0d a=%0d expected done=1 writes=6 a=5",
                  initDoneB, wrCntB, AddressB);
      else passCnt++;
      w0 = wrCntB; r0 = rdCntB;
      ifB.rsp_ready = 1'b1;
      ifB.cmd_valid = 1'b1; ifB.cmd_write = 1'b1; ifB.cmd_addr = 3'd7; ifB.cmd_wdata = 16'd9;
      totalCnt++;
      if (ifB.cmd_ready !== 1'b1)
         $display("FAIL oor_ready: got rdy=%b expected rdy=1", ifB.cmd_ready);
      else passCnt++;
      @(negedge CLK);
      ifB.cmd_valid = 1'b0;
      totalCnt++;
      if (WrEnB !== 1'b0 || ifB.cmd_ready !== 1'b0)
         $display("FAIL oor_write: got we=%b rdy=%b expected we=0 rdy=0", WrEnB, ifB.cmd_ready);
      else passCnt++;
      @(negedge CLK);
      ifB.cmd_valid = 1'b1; ifB.cmd_write = 1'b0; ifB.cmd_addr = 3'd7; ifB.cmd_wdata = 16'h0;
      @(negedge CLK);
      ifB.cmd_valid = 1'b0;
      totalCnt++;
      if (ifB.rsp_valid !== 1'b1 || ifB.rsp_err !== 1'b1 || ifB.rsp_rdata !== 16'h0 || RdEnB !== 1'b0)
         $display("FAIL oor_read: got rv=%b err=%b rd=%0h re=%b expected rv=1 err=1 rd=0 re=0",
                  ifB.rsp_valid, ifB.rsp_err, ifB.rsp_rdata, RdEnB);
      else passCnt++;
      @(negedge CLK);
      totalCnt++;
      if (ifB.rsp_valid !== 1'b0 || ifB.cmd_ready !== 1'b1 || wrCntB != w0 || rdCntB != r0)
         $display("FAIL oor_end: got rv=%b rdy=%b wr=%0d rd=%0d expected rv=0 rdy=1 wr=0 rd=0",
                  ifB.rsp_valid, ifB.cmd_ready, wrCntB - w0, rdCntB - r0);
      else passCnt++;
   endtask

   task automatic test_reset_mid_read();
      int w0, n;
      bit acc, seen;
      ifA.rsp_ready = 1'b1;
      sendA(1'b0, 3'd3, 16'h0, acc);
      @(negedge CLK);
      rstA = 1'b1;
      @(negedge CLK);
      rstA = 1'b0;
      totalCnt++;
      if ({WrEnA, RdEnA, AddressA, WrDataA, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err,
           initDoneA, ifA.cmd_ready} !== '0)
         $display("FAIL rst_mid_values: got we=%b re=%b a=%0d wd=%0h rv=%b rd=%0h err=%b done=%b rdy=%b expected all 0",
                  WrEnA, RdEnA, AddressA, WrDataA, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err,
                  initDoneA, ifA.cmd_ready);
      else passCnt++;
      w0 = wrCntA; seen = 1'b0; n = 0;
      while (initDoneA !== 1'b1 && n < 30) begin
         @(negedge CLK);
         if (ifA.rsp_valid === 1'b1) seen = 1'b1;
         n++;
      end
      totalCnt++;
      if (initDoneA !== 1'b1 || seen || wrCntA - w0 != 8)
         $display("FAIL rst_mid_sweep: got done=%b rv_seen=%b writes=%0d expected done=1 rv_seen=0 writes=8",
                  initDoneA, seen, wrCntA - w0);
      else passCnt++;
      sendA(1'b0, 3'd3, 16'h0, acc);
      @(negedge CLK);
      @(negedge CLK);
      totalCnt++;
      if (!acc || ifA.rsp_valid !== 1'b1 || ifA.rsp_rdata !== 16'h0 || ifA.rsp_err !== 1'b0)
         $display("FAIL rst_mid_reread: got acc=%b rv=%b rd=%0h err=%b expected acc=1 rv=1 rd=0 err=0",
                  acc, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err);
      else passCnt++;
      @(negedge CLK);
   endtask

   initial begin
      rstA = 1'b1; rstB = 1'b1;
      ifA.cmd_valid = 1'b0; ifA.cmd_write = 1'b0; ifA.cmd_addr = '0; ifA.cmd_wdata = '0;
      ifA.rsp_ready = 1'b0;
      ifB.cmd_valid = 1'b0; ifB.cmd_write = 1'b0; ifB.cmd_addr = '0; ifB.cmd_wdata = '0;
      ifB.rsp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_resp_hold();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule

// File: doc/regfile_initiator.md
# regfile_initiator

Bus initiator that drives the host side of the 8 x 16 register file (WrData, Address, WrEn, RdEn, RdData). It accepts read and write commands over a valid/ready handshake and turns each into a correctly timed single-cycle register-file access. Read data comes back over a held response handshake. After reset it can optionally clear every location before it accepts commands. It sits between any command source (sequencer, UART bridge, CPU stub) and the register file.

## Interface
Parameters:
- WIDTH, 16, data width; must equal register file width
- DEPTH, 8, number of register file locations
- ADDR_W, 3, address width; DEPTH <= 2**ADDR_W
- RD_LAT, 1, cycles from the RdEn sampling edge until RdData is captured; legal range 1..4
- INIT_EN, 1, 1 = write INIT_VALUE to every location after reset
- INIT_VALUE, 0, data written during the init sweep

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  WIDTH  write data; ignored for reads
- rsp_valid  out  1  read response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at an edge
- rsp_rdata  out  WIDTH  read data
- rsp_err  out  1  1 = read address was out of range
- init_done  out  1  sticky; high once the init sweep has finished (or immediately if INIT_EN=0)
- WrEn  out  1  register file write enable
- RdEn  out  1  register file read enable
- Address  out  ADDR_W  register file address
- WrData  out  WIDTH  register file write data
- RdData  in  WIDTH  register file read data, registered inside the register file

## Operation
- All outputs are registered, except cmd_ready = (state == IDLE).
- States: INIT, IDLE, WRITE, READ, WAIT, RESP.
- Reset values: WrEn=0, RdEn=0, Address=0, WrData=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, internal counters=0.
- After reset the state is INIT if INIT_EN=1, otherwise IDLE with init_done=1.
- INIT: one write per cycle with WrEn=1, Address=0..DEPTH-1, WrData=INIT_VALUE.
  - After the write to DEPTH-1: IDLE, WrEn=0, init_done=1.
  - cmd_ready stays low throughout.
- IDLE: on accept, latch cmd_write, cmd_addr and cmd_wdata.
  - Write: go to WRITE.
  - Read with cmd_addr < DEPTH: go to READ.
  - Read with cmd_addr >= DEPTH: go straight to RESP with rsp_rdata=0, rsp_err=1.
- WRITE: exactly one cycle of WrEn=1 with the latched Address and WrData, then IDLE.
  - Address >= DEPTH: WrEn stays 0 and the write is silently dropped.
  - Writes produce no response.
- READ: exactly one cycle of RdEn=1 with the latched Address, then WAIT.
- WAIT: lasts RD_LAT cycles. On the final WAIT edge: rsp_rdata <= RdData, rsp_err <= 0, rsp_valid <= 1, go to RESP.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready. On the handshake edge: rsp_valid <= 0, go to IDLE.
- WrEn and RdEn are never high together. Address and WrData hold their last values when the enables are low.

## Timing
- Write: accept at edge E0 -> WrEn=1 during cycle E0..E1 -> cmd_ready high again after E1. Peak rate is one write per 2 cycles.
- Read, RD_LAT=1: accept at E0 -> RdEn=1 during E0..E1 -> register file updates RdData at E1 -> capture at E2 -> rsp_valid high after E2.
- General read latency: acceptance edge to rsp_valid is RD_LAT+1 edges.
- rsp_ready may already be high when rsp_valid rises. The handshake then completes at the next edge and cmd_ready is high one cycle later.
- Out-of-range read: rsp_valid high one edge after acceptance.
- Init sweep: DEPTH cycles. init_done and cmd_ready rise together after the last init edge.
- RST has priority over everything, including mid-sweep, mid-read and a pending response. Any response not yet consumed is discarded, all outputs return to their reset values, and INIT restarts.
- cmd_valid during INIT, WRITE, READ, WAIT or RESP is not accepted. The source must hold the command.

## Test plan
- Reset release with INIT_EN=1, DEPTH=8 -> 8 consecutive cycles of WrEn=1 at Address 0..7 with WrData=0, then init_done=1 and cmd_ready=1.
- Write addr 2 data 14, then read addr 2, with RD_LAT=1 and rsp_ready=1 -> exactly one WrEn pulse, exactly one RdEn pulse, rsp_valid 2 edges after read acceptance, rsp_rdata=14, rsp_err=0.
- Write addr 3 data 6, read addr 3, hold rsp_ready=0 for 5 cycles -> rsp_valid=1 with rsp_rdata=6 stable for all 5 cycles, cmd_ready=0 throughout, then IDLE one edge after rsp_ready=1.
- DEPTH=6, ADDR_W=3: write addr 7 data 9, then read addr 7 -> no WrEn and no RdEn pulse, rsp_valid after 1 edge with rsp_err=1 and rsp_rdata=0.
- RST asserted for 1 cycle during WAIT of a read to addr 3 -> rsp_valid never rises, outputs return to reset values, the init sweep reruns, and a later read of addr 3 returns 0.
- Back-to-back commands with cmd_valid held high (write 5->addr1, read addr1) -> second command accepted only when cmd_ready returns, rsp_rdata=5.
